// File: rtl/rr_tdm_demux.sv
// Round-robin TDM slot de-interleaver with frame-sync lock FSM and a ready/valid frame output.
// Optional saturating error counter is built when RR_TDM_DEMUX_ERR_CNT_EN is defined.
module rr_tdm_demux #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_WIDTH-1:0]              din,
  input  logic                               din_valid,
  input  logic                               frame_sync,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] dout,
  output logic                               dout_valid,
  input  logic                               dout_ready,
  output logic                               locked,
  output logic                               sync_err,
  output logic                               overrun,
  output logic [7:0]                         err_cnt
);

  localparam int SLOT_W = $clog2(NUM_CHANNELS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CHANNELS - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                           state;
  logic [SLOT_W-1:0]                slot;
  logic [DATA_WIDTH-1:0]            bank [NUM_CHANNELS];

  logic                             realign;
  logic                             drop;
  logic                             store_en;
  logic                             frame_done;
  logic                             sync_ev;
  logic                             ovr_ev;
  logic                             load;
  logic                             handshake;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] frame_w;

  // Beat classification: realign also covers the initial acquisition out of HUNT.
  always_comb begin
    realign    = 1'b0;
    drop       = 1'b0;
    store_en   = 1'b0;
    frame_done = 1'b0;
    if (din_valid) begin
      if (state == HUNT) begin
        realign = frame_sync;
      end else if (frame_sync && (slot != '0)) begin
        realign = 1'b1;
      end else if (!frame_sync && (slot == '0)) begin
        drop = 1'b1;
      end else begin
        store_en   = 1'b1;
        frame_done = (slot == LAST_SLOT);
      end
    end
  end

  assign sync_ev   = (realign && (state == LOCKED)) || drop;
  assign handshake = dout_valid && dout_ready;
  assign load      = frame_done && (!dout_valid || dout_ready);
  assign ovr_ev    = frame_done && !load;
  assign locked    = (state == LOCKED);

  // The final slot bypasses the bank so the frame is presented one cycle after its last beat.
  always_comb begin
    frame_w = '0;
    for (int k = 0; k < NUM_CHANNELS - 1; k++) begin
      frame_w[k*DATA_WIDTH +: DATA_WIDTH] = bank[k];
    end
    frame_w[(NUM_CHANNELS-1)*DATA_WIDTH +: DATA_WIDTH] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      slot       <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        bank[k] <= '0;
      end
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync_err <= sync_ev;
      overrun  <= ovr_ev;

      if (realign) begin
        state   <= LOCKED;
        slot    <= SLOT_W'(1);
        bank[0] <= din;
      end else if (drop) begin
        state <= HUNT;
      end else if (store_en) begin
        bank[slot] <= din;
        slot       <= frame_done ? '0 : slot + SLOT_W'(1);
      end

      if (load) begin
        dout       <= frame_w;
        dout_valid <= 1'b1;
      end else if (handshake) begin
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef RR_TDM_DEMUX_ERR_CNT_EN
  // A cycle with both events still counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if ((sync_ev || ovr_ev) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rr_tdm_demux.sv
// Directed bench for rr_tdm_demux (2 channels x 16 bits) with a frame scoreboard on the output handshake.
module tb_rr_tdm_demux;

  localparam int W = 16;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   din;
  logic           din_valid;
  logic           frame_sync;
  logic [N*W-1:0] dout;
  logic           dout_valid;
  logic           dout_ready;
  logic           locked;
  logic           sync_err;
  logic           overrun;
  logic [7:0]     err_cnt;

  int total  = 0;
  int passed = 0;
  logic [N*W-1:0] sb_q [$];

  rr_tdm_demux #(.DATA_WIDTH(W), .NUM_CHANNELS(N)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .locked(locked),
    .sync_err(sync_err), .overrun(overrun), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d, input logic fs);
    din = d; frame_sync = fs; din_valid = 1'b1;
    step();
    din_valid = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic idle();
    din_valid = 1'b0; frame_sync = 1'b0;
    step();
  endtask

  // Scoreboard: every accepted frame must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && dout_valid && dout_ready) begin
      if (sb_q.size() == 0) chk("sb_unexpected_frame", dout, 32'hDEAD_BEEF);
      else chk("sb_frame", dout, sb_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0; dout_ready = 1'b1;
    #1;
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_dout", dout, 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Basic two-slot frame
    beat(16'h1111, 1'b1);
    chk("lock_after_sync", 32'(locked), 1);
    sb_q.push_back(32'h2222_1111);
    beat(16'h2222, 1'b0);
    chk("frame1_valid", 32'(dout_valid), 1);
    chk("frame1_dout", dout, 32'h2222_1111);
    idle();
    chk("frame1_valid_drop", 32'(dout_valid), 0);

    // Realign on early sync
    beat(16'hAAAA, 1'b1);
    chk("no_err_slot0_sync", 32'(sync_err), 0);
    beat(16'hBBBB, 1'b1);
    chk("realign_sync_err", 32'(sync_err), 1);
    chk("realign_locked", 32'(locked), 1);
    sb_q.push_back(32'hCCCC_BBBB);
    beat(16'hCCCC, 1'b0);
    chk("realign_dout", dout, 32'hCCCC_BBBB);
    chk("realign_err_cleared", 32'(sync_err), 0);
    idle();

    // Missing sync on slot 0 loses lock
    beat(16'hDDDD, 1'b0);
    chk("lost_sync_err", 32'(sync_err), 1);
    chk("lost_locked", 32'(locked), 0);
    beat(16'h1234, 1'b0);
    beat(16'h5678, 1'b0);
    idle();
    chk("hunt_no_valid", 32'(dout_valid), 0);
    chk("hunt_locked", 32'(locked), 0);

    // Backpressure: second frame dropped
    dout_ready = 1'b0;
    beat(16'h0101, 1'b1);
    sb_q.push_back(32'h0202_0101);
    beat(16'h0202, 1'b0);
    beat(16'h0303, 1'b1);
    chk("pre_overrun_quiet", 32'(overrun), 0);
    beat(16'h0404, 1'b0);
    chk("overrun_pulse", 32'(overrun), 1);
    chk("overrun_held_dout", dout, 32'h0202_0101);
    idle();
    chk("overrun_one_cycle", 32'(overrun), 0);
    chk("overrun_valid_held", 32'(dout_valid), 1);
    dout_ready = 1'b1;
    idle();
    chk("overrun_accept_drop", 32'(dout_valid), 0);

    // Handshake coinciding with completion: no bubble
    dout_ready = 1'b0;
    beat(16'h0505, 1'b1);
    sb_q.push_back(32'h0606_0505);
    beat(16'h0606, 1'b0);
    beat(16'h0707, 1'b1);
    dout_ready = 1'b1;
    sb_q.push_back(32'h0808_0707);
    beat(16'h0808, 1'b0);
    chk("b2b_dout", dout, 32'h0808_0707);
    chk("b2b_valid", 32'(dout_valid), 1);
    chk("b2b_no_overrun", 32'(overrun), 0);
    idle();
    chk("b2b_valid_drop", 32'(dout_valid), 0);

    // Reset mid-frame with a frame pending
    dout_ready = 1'b0;
    beat(16'h0A0A, 1'b1);
    beat(16'h0B0B, 1'b0);
    beat(16'h0C0C, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(dout_valid), 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_err_cnt", 32'(err_cnt), 0);
    step();
    rst_n = 1'b1;
    dout_ready = 1'b1;
    step();
    beat(16'h0D0D, 1'b0);
    beat(16'h0E0E, 1'b0);
    idle();
    chk("post_rst_needs_sync", 32'(dout_valid), 0);
    chk("post_rst_hunt", 32'(locked), 0);

    // 300 consecutive realign errors
    beat(16'h0F0F, 1'b1);
    for (int i = 0; i < 300; i++) beat(16'(i), 1'b1);
    chk("storm_sync_err", 32'(sync_err), 1);
    idle();
`ifdef RR_TDM_DEMUX_ERR_CNT_EN
    chk("err_cnt_saturated", 32'(err_cnt), 255);
`else
    chk("err_cnt_tied_zero", 32'(err_cnt), 0);
`endif
    chk("storm_no_frame", 32'(dout_valid), 0);
    idle();
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rr_tdm_demux.md
RR_TDM_DEMUX -- requirements
Module: rr_tdm_demux

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, width of each TDM slot word.
REQ-002 Parameter: NUM_CHANNELS, default 2, slots per frame; legal range 2..16.
REQ-003 Port: clk  input  1  single clock; every register is rising-edge clocked in this domain.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: din  input  DATA_WIDTH  serialized TDM slot word.
REQ-006 Port: din_valid  input  1  din carries a slot word this cycle.
REQ-007 Port: frame_sync  input  1  qualified by din_valid; marks slot 0 of a frame.
REQ-008 Port: dout  output  NUM_CHANNELS*DATA_WIDTH  de-interleaved frame; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port: dout_valid  output  1  dout holds a complete frame.
REQ-010 Port: dout_ready  input  1  consumer accepts dout when dout_valid is also 1.
REQ-011 Port: locked  output  1  FSM is in LOCKED.
REQ-012 Port: sync_err  output  1  one-cycle pulse on a framing error.
REQ-013 Port: overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-014 Port: err_cnt  output  8  saturating error count (see Configuration).

Function
REQ-015 The FSM SHALL have two states, HUNT and LOCKED, plus a slot counter (0..NUM_CHANNELS-1) and a capture register bank.
REQ-016 HUNT: a beat with din_valid=1 and frame_sync=1 SHALL be stored to channel 0; set slot to 1; go to LOCKED. All other beats are ignored.
REQ-017 LOCKED: each din_valid beat SHALL be stored to channel slot; slot increments and wraps from NUM_CHANNELS-1 to 0. Cycles with din_valid=0 hold all state.
REQ-018 LOCKED, frame_sync=1 on a beat with slot!=0: pulse sync_err; discard the partial frame; store the beat as channel 0; set slot to 1; stay LOCKED (realign).
REQ-019 LOCKED, frame_sync=0 on a beat with slot==0: pulse sync_err; discard the beat; go to HUNT.
REQ-020 Frame completes on the beat stored to slot NUM_CHANNELS-1; the full frame SHALL appear on dout with dout_valid=1 on the next cycle (latency 1 from the last beat).
REQ-021 dout and dout_valid SHALL hold until a cycle with dout_valid && dout_ready.
REQ-022 Frame completes while dout_valid=1 and dout_ready=0: pulse overrun; drop the new frame; retain the old frame.
REQ-023 Frame completes in the same cycle as a handshake: load the new frame; dout_valid stays 1 with no bubble; no overrun.
REQ-024 Handshake with no frame completing: dout_valid goes to 0 on the next cycle.
REQ-025 sync_err and overrun SHALL each be asserted for exactly one cycle per event. Both may fire in the same cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force:
- state to HUNT and slot to 0;
- capture bank, dout and err_cnt to 0;
- dout_valid, locked, sync_err and overrun to 0.
REQ-027 A reset asserted mid-frame or while dout_valid=1 SHALL discard all data. The first valid frame after release requires a new frame_sync.

Configuration
REQ-028 Macro RR_TDM_DEMUX_ERR_CNT_EN.
- Defined: err_cnt increments by 1 in each cycle where sync_err or overrun fires (by 1 even if both fire), saturates at 255, and clears only on reset.
- Undefined: err_cnt is tied to 0 and no counter logic is built.

Verification
REQ-029 NUM_CHANNELS=2, DATA_WIDTH=16, dout_ready=1. Beats 0x1111(sync), 0x2222 -> next cycle dout=0x2222_1111, dout_valid=1 for 1 cycle, locked=1.
REQ-030 Locked. Beat 0xAAAA(sync) then 0xBBBB(sync) -> sync_err pulses on the second beat. A following 0xCCCC gives dout=0xCCCC_BBBB.
REQ-031 Locked. Slot-0 beat without sync -> sync_err pulses, locked=0 next cycle. Later unsynced beats produce no dout_valid.
REQ-032 dout_ready=0 and two complete frames -> first frame held, overrun pulses once. Then dout_ready=1 -> first frame accepted, dout_valid drops.
REQ-033 dout_valid=1 with dout_ready=1 in the same cycle the last beat of frame 2 arrives -> dout updates to frame 2, dout_valid stays 1, overrun=0.
REQ-034 rst_n low mid-frame -> all outputs 0 immediately. With the macro defined, 300 sync errors -> err_cnt=255.
